clock_set_ctrl: RTL and testbench

Time-setting controller for the hour/minute/second clock counter chain. It takes debounced single-cycle button pulses and captures the running time into shadow registers. The user edits hour, minute and second fields in turn, with wrap-around. The block then drives the chain's shared load strobe and load values for a programmable number of cycles. It sits between the front-panel button logic and the clock counter top level.

---
 rtl/clock_set_ctrl.sv | 125 ++++++++++++
 tb/tb_clock_set_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - time-setting controller for the hour/minute/second counter chain
module clock_set_ctrl #(
    parameter int HOUR_MAX    = 23,
    parameter int MIN_MAX     = 59,
    parameter int TIMEOUT     = 1000,
    parameter int LOAD_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    input  logic [5:0] sec_count,
    input  logic [5:0] min_count,
    input  logic [5:0] hour_count,
    output logic       load_out,
    output logic [5:0] sec_set,
    output logic [5:0] min_set,
    output logic [5:0] hour_set,
    output logic       editing,
    output logic [1:0] field_sel
);

    localparam logic [2:0] ST_RUN       = 3'd0;
    localparam logic [2:0] ST_EDIT_HOUR = 3'd1;
    localparam logic [2:0] ST_EDIT_MIN  = 3'd2;
    localparam logic [2:0] ST_EDIT_SEC  = 3'd3;
    localparam logic [2:0] ST_COMMIT    = 3'd4;

    localparam logic [5:0] HMAX    = 6'(HOUR_MAX);
    localparam logic [5:0] MMAX    = 6'(MIN_MAX);
    localparam int         IW      = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [3:0] LOAD_LAST = 4'(LOAD_CYCLES - 1);

    logic [2:0]    state;
    logic [IW-1:0] idle_cnt;
    logic [3:0]    load_cnt;

    function automatic logic [5:0] step_field(input logic [5:0] v, input logic [5:0] max,
                                              input logic up);
        if (up) return (v == max) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? max : v - 6'd1;
    endfunction

    function automatic logic [5:0] clamp_capture(input logic [5:0] v, input logic [5:0] max);
        return (v > max) ? 6'd0 : v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            load_out  <= 1'b0;
            sec_set   <= 6'd0;
            min_set   <= 6'd0;
            hour_set  <= 6'd0;
            editing   <= 1'b0;
            field_sel <= 2'd0;
            idle_cnt  <= '0;
            load_cnt  <= 4'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    load_out <= 1'b0;
                    if (mode_btn) begin
                        hour_set  <= clamp_capture(hour_count, HMAX);
                        min_set   <= clamp_capture(min_count, MMAX);
                        sec_set   <= clamp_capture(sec_count, MMAX);
                        state     <= ST_EDIT_HOUR;
                        editing   <= 1'b1;
                        field_sel <= 2'd1;
                        idle_cnt  <= '0;
                    end
                end
                ST_EDIT_HOUR, ST_EDIT_MIN, ST_EDIT_SEC: begin
                    // mode wins over a same-cycle inc/dec, which is dropped
                    if (mode_btn) begin
                        idle_cnt <= '0;
                        if (state == ST_EDIT_SEC) begin
                            state     <= ST_COMMIT;
                            editing   <= 1'b0;
                            field_sel <= 2'd0;
                            load_out  <= 1'b1;
                            load_cnt  <= LOAD_LAST;
                        end else begin
                            state     <= 3'(state + 3'd1);
                            field_sel <= 2'(field_sel + 2'd1);
                        end
                    end else if (inc_btn || dec_btn) begin
                        idle_cnt <= '0;
                        if (inc_btn != dec_btn) begin
                            case (state)
                                ST_EDIT_HOUR: hour_set <= step_field(hour_set, HMAX, inc_btn);
                                ST_EDIT_MIN:  min_set  <= step_field(min_set, MMAX, inc_btn);
                                default:      sec_set  <= step_field(sec_set, MMAX, inc_btn);
                            endcase
                        end
                    end else if (idle_cnt == IDLE_LAST) begin
                        state     <= ST_RUN;
                        editing   <= 1'b0;
                        field_sel <= 2'd0;
                        idle_cnt  <= '0;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_COMMIT: begin
                    if (load_cnt == 4'd0) begin
                        load_out <= 1'b0;
                        state    <= ST_RUN;
                    end else begin
                        load_cnt <= load_cnt - 4'd1;
                    end
                end
                default: begin
                    state     <= ST_RUN;
                    load_out  <= 1'b0;
                    editing   <= 1'b0;
                    field_sel <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed vector bench for clock_set_ctrl
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0;
    logic [5:0] sec_count = '0, min_count = '0, hour_count = '0;

    logic       o1_load, o1_ed, o4_load, o4_ed;
    logic [5:0] o1_s, o1_m, o1_h, o4_s, o4_m, o4_h;
    logic [1:0] o1_f, o4_f;
    logic [5:0] chain_h = '0, chain_m = '0, chain_s = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clock_set_ctrl #(.HOUR_MAX(23), .MIN_MAX(59), .TIMEOUT(8), .LOAD_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .sec_count(sec_count), .min_count(min_count), .hour_count(hour_count),
        .load_out(o1_load), .sec_set(o1_s), .min_set(o1_m), .hour_set(o1_h),
        .editing(o1_ed), .field_sel(o1_f));

    clock_set_ctrl #(.HOUR_MAX(23), .MIN_MAX(59), .TIMEOUT(8), .LOAD_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .sec_count(sec_count), .min_count(min_count), .hour_count(hour_count),
        .load_out(o4_load), .sec_set(o4_s), .min_set(o4_m), .hour_set(o4_h),
        .editing(o4_ed), .field_sel(o4_f));

    // Simple model of the counter chain accepting the load strobe
    always @(posedge clk) begin
        if (o1_load) begin
            chain_h <= o1_h;
            chain_m <= o1_m;
            chain_s <= o1_s;
        end
    end

    typedef struct {
        logic       m, i, d;
        logic [5:0] hc, mc, sc;
        logic       ed;
        logic [1:0] fs;
        logic [5:0] h, mm, s;
        logic       ld;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic m, i, d, input int hc, mc, sc,
                       input logic ed, input int fs, h, mm, s, input logic ld);
        vec_t v;
        v.m = m; v.i = i; v.d = d;
        v.hc = 6'(hc); v.mc = 6'(mc); v.sc = 6'(sc);
        v.ed = ed; v.fs = 2'(fs); v.h = 6'(h); v.mm = 6'(mm); v.s = 6'(s); v.ld = ld;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic m, i, d);
        @(negedge clk);
        mode_btn = m; inc_btn = i; dec_btn = d;
        @(posedge clk);
        #1;
        mode_btn = 1'b0; inc_btn = 1'b0; dec_btn = 1'b0;
    endtask

    initial begin
        // basic edit with both-button and mode+inc corner cases
        add(1,0,0, 13,45,7,  1,1, 13,45,7,  0);
        add(0,0,1, 13,45,7,  1,1, 12,45,7,  0);
        add(0,1,1, 13,45,7,  1,1, 12,45,7,  0);
        add(1,0,0, 13,45,7,  1,2, 12,45,7,  0);
        add(0,1,1, 13,45,7,  1,2, 12,45,7,  0);
        add(1,1,0, 13,45,7,  1,3, 12,45,7,  0);
        add(0,0,1, 13,45,7,  1,3, 12,45,6,  0);
        add(1,0,0, 13,45,7,  0,0, 12,45,6,  1);
        add(0,1,0, 13,45,7,  0,0, 12,45,6,  0);
        add(0,0,1, 13,45,7,  0,0, 12,45,6,  0);
        // wrap-around at both ends of every field
        add(1,0,0, 23,59,0,  1,1, 23,59,0,  0);
        add(0,1,0, 23,59,0,  1,1, 0,59,0,   0);
        add(0,0,1, 23,59,0,  1,1, 23,59,0,  0);
        add(1,0,0, 23,59,0,  1,2, 23,59,0,  0);
        add(0,1,0, 23,59,0,  1,2, 23,0,0,   0);
        add(0,0,1, 23,59,0,  1,2, 23,59,0,  0);
        add(1,0,0, 23,59,0,  1,3, 23,59,0,  0);
        add(0,0,1, 23,59,0,  1,3, 23,59,59, 0);
        add(0,1,0, 23,59,0,  1,3, 23,59,0,  0);
        add(1,0,0, 23,59,0,  0,0, 23,59,0,  1);
        add(0,0,0, 23,59,0,  0,0, 23,59,0,  0);
        // out-of-range capture stored as zero
        add(1,0,0, 30,63,60, 1,1, 0,0,0,    0);
        add(1,0,0, 30,63,60, 1,2, 0,0,0,    0);
        add(1,0,0, 30,63,60, 1,3, 0,0,0,    0);
        add(1,0,0, 30,63,60, 0,0, 0,0,0,    1);
        add(0,0,0, 30,63,60, 0,0, 0,0,0,    0);
        // full sequence 10:00:00 -> 12:59:05
        add(1,0,0, 10,0,0,   1,1, 10,0,0,   0);
        add(0,1,0, 10,0,0,   1,1, 11,0,0,   0);
        add(0,1,0, 10,0,0,   1,1, 12,0,0,   0);
        add(1,0,0, 10,0,0,   1,2, 12,0,0,   0);
        add(0,0,1, 10,0,0,   1,2, 12,59,0,  0);
        add(1,0,0, 10,0,0,   1,3, 12,59,0,  0);
        for (int k = 1; k <= 5; k++) add(0,1,0, 10,0,0, 1,3, 12,59,k, 0);
        add(1,0,0, 10,0,0,   0,0, 12,59,5,  1);
        add(0,0,0, 10,0,0,   0,0, 12,59,5,  0);

        #1;
        chk("reset_load", int'(o1_load), 0);
        chk("reset_editing", int'(o1_ed), 0);
        chk("reset_field", int'(o1_f), 0);
        chk("reset_sets", int'({o1_h, o1_m, o1_s}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int n = 0; n < tbl.size(); n++) begin
            hour_count = tbl[n].hc; min_count = tbl[n].mc; sec_count = tbl[n].sc;
            step(tbl[n].m, tbl[n].i, tbl[n].d);
            chk($sformatf("v%0d_editing", n), int'(o1_ed), int'(tbl[n].ed));
            chk($sformatf("v%0d_field", n), int'(o1_f), int'(tbl[n].fs));
            chk($sformatf("v%0d_hour", n), int'(o1_h), int'(tbl[n].h));
            chk($sformatf("v%0d_min", n), int'(o1_m), int'(tbl[n].mm));
            chk($sformatf("v%0d_sec", n), int'(o1_s), int'(tbl[n].s));
            chk($sformatf("v%0d_load", n), int'(o1_load), int'(tbl[n].ld));
        end
        chk("chain_hour", int'(chain_h), 12);
        chk("chain_min", int'(chain_m), 59);
        chk("chain_sec", int'(chain_s), 5);

        // timeout with no activity
        hour_count = 6'd5; min_count = 6'd6; sec_count = 6'd7;
        step(1, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            step(0, 0, 0);
            chk($sformatf("to_idle%0d_editing", k), int'(o1_ed), 1);
            chk($sformatf("to_idle%0d_load", k), int'(o1_load), 0);
        end
        step(0, 0, 0);
        chk("to_exit_editing", int'(o1_ed), 0);
        chk("to_exit_field", int'(o1_f), 0);
        chk("to_exit_load", int'(o1_load), 0);
        chk("to_exit_retained", int'({o1_h, o1_m, o1_s}), int'({6'd5, 6'd6, 6'd7}));

        // inc at cycle 5 restarts the idle count
        step(1, 0, 0);
        for (int k = 1; k <= 4; k++) step(0, 0, 0);
        step(0, 1, 0);
        chk("tor_inc_hour", int'(o1_h), 6);
        for (int k = 1; k <= 7; k++) begin
            step(0, 0, 0);
            chk($sformatf("tor_idle%0d_editing", k), int'(o1_ed), 1);
            chk($sformatf("tor_idle%0d_load", k), int'(o1_load), 0);
        end
        step(0, 0, 0);
        chk("tor_exit_editing", int'(o1_ed), 0);
        chk("tor_exit_load", int'(o1_load), 0);
        chk("tor_exit_hour", int'(o1_h), 6);

        // asynchronous reset in the middle of a 4-cycle commit
        hour_count = 6'd1; min_count = 6'd2; sec_count = 6'd3;
        for (int k = 0; k < 4; k++) step(1, 0, 0);
        chk("c4_load_first", int'(o4_load), 1);
        chk("c4_hour", int'(o4_h), 1);
        step(0, 0, 0);
        chk("c4_load_second", int'(o4_load), 1);
        #2 rst = 1'b1;
        #1;
        chk("c4_async_load", int'(o4_load), 0);
        chk("c4_async_sets", int'({o4_h, o4_m, o4_s}), 0);
        chk("c4_async_editing", int'(o4_ed), 0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0);
        chk("c4_after_load", int'(o4_load), 0);
        chk("c4_after_field", int'(o4_f), 0);
        step(1, 0, 0);
        chk("c4_run_capture_field", int'(o4_f), 1);
        chk("c4_run_capture_sets", int'({o4_h, o4_m, o4_s}), int'({6'd1, 6'd2, 6'd3}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
